// File: rtl/time_set_input.sv
// time_set_input: synchronizes/debounces the time-set controls and turns QD presses into hour/minute increment pulses with auto-repeat.
module time_set_input #(
    parameter int DEBOUNCE_CYC  = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic K0,
    input  logic K1,
    input  logic K2,
    input  logic QD,
    output logic hour_inc,
    output logic min_inc,
    output logic qd_clean,
    output logic adj_active
);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} state_t;
    state_t state, state_n;
    logic [1:0] k0_r, k1_r, k2_r, qd_r;
    logic k0_s, k1_s, k2_s, qd_s;
    logic [CNT_W-1:0] deb_cnt, rpt_cnt, rpt_n;
    logic qd_clean_d, press, fire;
    assign k0_s = k0_r[1];
    assign k1_s = k1_r[1];
    assign k2_s = k2_r[1];
    assign qd_s = qd_r[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k0_r       <= '0;
            k1_r       <= '0;
            k2_r       <= '0;
            qd_r       <= '0;
            deb_cnt    <= '0;
            qd_clean   <= 1'b0;
            qd_clean_d <= 1'b0;
            press      <= 1'b0;
            state      <= IDLE;
            rpt_cnt    <= '0;
            hour_inc   <= 1'b0;
            min_inc    <= 1'b0;
            adj_active <= 1'b0;
        end else begin
            k0_r <= {k0_r[0], K0};
            k1_r <= {k1_r[0], K1};
            k2_r <= {k2_r[0], K2};
            qd_r <= {qd_r[0], QD};
            // any matching sample throws away debounce progress
            if (qd_s == qd_clean) deb_cnt <= '0;
            else if (deb_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                deb_cnt  <= '0;
                qd_clean <= ~qd_clean;
            end else deb_cnt <= deb_cnt + 1'b1;
            qd_clean_d <= qd_clean;
            press      <= qd_clean & ~qd_clean_d;
            state      <= state_n;
            rpt_cnt    <= rpt_n;
            hour_inc   <= fire & k1_s;
            min_inc    <= fire & ~k1_s & k2_s;
            adj_active <= k0_s;
        end
    end
    always_comb begin
        state_n = state;
        rpt_n   = rpt_cnt;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (press && k0_s) begin
                    fire    = 1'b1;
                    state_n = HOLD;
                    rpt_n   = CNT_W'(REPEAT_DELAY - 1);
                end else if (!k0_s && qd_clean) state_n = LOCKOUT;
            end
            HOLD, REPEAT: begin
                if (!qd_clean) state_n = IDLE;
                else if (!k0_s) state_n = LOCKOUT;
                else if (rpt_cnt == '0) begin
                    fire    = 1'b1;
                    state_n = REPEAT;
                    rpt_n   = CNT_W'(REPEAT_PERIOD - 1);
                end else rpt_n = rpt_cnt - 1'b1;
            end
            LOCKOUT: state_n = qd_clean ? LOCKOUT : IDLE;
        endcase
    end
endmodule

// File: tb/tb_time_set_input.sv
// tb_time_set_input: directed press scenarios checked every cycle against an event-time model of the time-set front end.
module tb_time_set_input;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    logic K0 = 1'b0, K1 = 1'b0, K2 = 1'b0, QD = 1'b0;
    logic hour_inc, min_inc, qd_clean, adj_active;
    int vectors = 0, misc = 0, cyc = 0, rises = 0, base = 0;
    int hq[$], mq[$];
    logic clean_prev = 1'b0;
    logic [3:0] act_v, exp_v;
    logic [1:0] sq = '0, sk0 = '0, sk1 = '0, sk2 = '0;
    logic [DB-1:0] win = '0;
    logic [2:0] cq = '0;
    logic clean = 1'b0, active = 1'b0, locked = 1'b0;
    logic qs, k0s, k1s, k2s, clean_b, press_m, fire;
    logic e_hour = 1'b0, e_min = 1'b0, e_clean = 1'b0, e_adj = 1'b0;
    int next_fire = 0;
    time_set_input #(.DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .K0(K0), .K1(K1), .K2(K2), .QD(QD),
        .hour_inc(hour_inc), .min_inc(min_inc), .qd_clean(qd_clean), .adj_active(adj_active)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic int at(input int q[$], input int i, input int b);
        return (i < q.size()) ? q[i] - b : -1;
    endfunction
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask
    // model: level changes after DB agreeing samples, pulses scheduled by absolute cycle
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            sq = '0; sk0 = '0; sk1 = '0; sk2 = '0; win = '0; cq = '0;
            clean = 1'b0; active = 1'b0; locked = 1'b0;
            e_hour = 1'b0; e_min = 1'b0; e_clean = 1'b0; e_adj = 1'b0;
        end else begin
            qs = sq[1]; k0s = sk0[1]; k1s = sk1[1]; k2s = sk2[1];
            sq = {sq[0], QD}; sk0 = {sk0[0], K0}; sk1 = {sk1[0], K1}; sk2 = {sk2[0], K2};
            clean_b = cq[0];
            press_m = cq[1] & ~cq[2];
            win = {win[DB-2:0], qs};
            if (win == {DB{~clean}}) clean = ~clean;
            cq = {cq[1:0], clean};
            fire = 1'b0;
            if (locked) locked = clean_b;
            else if (active) begin
                if (!k0s && clean_b) begin active = 1'b0; locked = 1'b1; end
                else if (!clean_b) active = 1'b0;
                else if (cyc == next_fire) begin fire = 1'b1; next_fire = cyc + RP; end
            end else if (press_m && k0s) begin
                fire = 1'b1; active = 1'b1; next_fire = cyc + RD;
            end else if (!k0s && clean_b) locked = 1'b1;
            e_hour = fire & k1s;
            e_min = fire & ~k1s & k2s;
            e_adj = k0s;
            e_clean = clean;
        end
    end
    always @(negedge clk) begin
        act_v = {hour_inc, min_inc, qd_clean, adj_active};
        exp_v = rst_n ? {e_hour, e_min, e_clean, e_adj} : 4'b0;
        check("outputs", int'(act_v), int'(exp_v));
        if (hour_inc) hq.push_back(cyc);
        if (min_inc) mq.push_back(cyc);
        if (qd_clean && !clean_prev) rises++;
        clean_prev = qd_clean;
    end
    initial begin
        QD = 1'b1; K0 = 1'b1; K1 = 1'b1; K2 = 1'b0;
        tick(4);
        rst_n = 1'b1; base = cyc + 1; hq.delete(); mq.delete();
        tick(12);
        check("t1_hour_count", hq.size(), 1);
        check("t1_hour_offset", at(hq, 0, base), 7);
        QD = 1'b0; tick(15);
        check("t1_released", int'(qd_clean), 0);
        K1 = 1'b0; K2 = 1'b1; tick(3);
        hq.delete(); mq.delete(); rises = 0;
        QD = 1'b1; tick(3); QD = 1'b0; tick(3); QD = 1'b1; tick(3); QD = 1'b0; tick(3);
        QD = 1'b1; base = cyc + 1;
        tick(9); QD = 1'b0; tick(15);
        check("t2_min_count", mq.size(), 1);
        check("t2_min_offset", at(mq, 0, base), 7);
        check("t2_hour_count", hq.size(), 0);
        check("t2_clean_rises", rises, 1);
        K1 = 1'b1; K2 = 1'b0; tick(3);
        hq.delete(); mq.delete();
        QD = 1'b1; base = cyc + 1;
        tick(35); QD = 1'b0; tick(20);
        check("t3_hour_count", hq.size(), 6);
        check("t3_first", at(hq, 0, base), 7);
        check("t3_delay", at(hq, 1, base), 17);
        check("t3_period", at(hq, 2, base), 22);
        check("t3_last", at(hq, 5, base), 37);
        check("t3_idle_clean", int'(qd_clean), 0);
        K1 = 1'b1; K2 = 1'b1; tick(3);
        hq.delete(); mq.delete();
        QD = 1'b1; base = cyc + 1;
        tick(10); K1 = 1'b0; tick(10); QD = 1'b0; tick(15);
        check("t4_hour_count", hq.size(), 1);
        check("t4_hour_offset", at(hq, 0, base), 7);
        check("t4_min_count", mq.size(), 2);
        check("t4_redirect", at(mq, 0, base), 17);
        K0 = 1'b0; K1 = 1'b1; K2 = 1'b0; tick(3);
        hq.delete(); mq.delete();
        QD = 1'b1; tick(12); K0 = 1'b1; tick(20);
        check("t5_lockout_count", hq.size(), 0);
        check("t5_adj_active", int'(adj_active), 1);
        QD = 1'b0; tick(12);
        QD = 1'b1; base = cyc + 1;
        tick(9); QD = 1'b0; tick(12);
        check("t5_repress_count", hq.size(), 1);
        check("t5_repress_offset", at(hq, 0, base), 7);
        hq.delete(); mq.delete();
        QD = 1'b1; base = cyc + 1;
        tick(20);
        check("t6_pre_reset_count", hq.size(), 2);
        rst_n = 1'b0; #1;
        check("t6_async_clear", int'({hour_inc, min_inc, qd_clean, adj_active}), 0);
        tick(3);
        rst_n = 1'b1; base = cyc + 1; hq.delete();
        tick(12);
        check("t6_restart_count", hq.size(), 1);
        check("t6_restart_offset", at(hq, 0, base), 7);
        QD = 1'b0; tick(15);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
